// File: rtl/pwm_ramp_pkg.sv
// Shared definitions for the multi-channel PWM ramp ADC.
//   max_cnt(nbits) : terminal value of an nbits-wide period counter
//   cw_of(nch)     : channel-index width, never narrower than 1 bit
//   result_t       : output slice payload {chan, value} at maximum widths
package pwm_ramp_pkg;

  localparam int unsigned RES_W  = 16;
  localparam int unsigned CHAN_W = 3;

  typedef struct packed {
    logic [CHAN_W-1:0] chan;
    logic [RES_W-1:0]  value;
  } result_t;

  function automatic int unsigned max_cnt(input int unsigned nbits);
    return (32'd1 << nbits) - 32'd1;
  endfunction

  function automatic int unsigned cw_of(input int unsigned nch);
    return (nch <= 1) ? 32'd1 : 32'($clog2(nch));
  endfunction

endpackage

// File: rtl/pwm_ramp_channel.sv
// One ramp-ADC channel: period counter, ramp register, registered PWM,
// lvds synchroniser with rising-edge detect, per-sweep capture, pending
// flag and sticky overrun.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   enable_i       : run; 0 freezes counters, ramp, sweep and edge capture
//   step_i         : ramp increment per PWM period
//   lvds_i         : asynchronous comparator input
//   grant_i        : arbiter is loading res_o into the output slice
//   pwm_o          : registered PWM
//   res_o, pend_o  : captured result and its pending flag
//   overrun_o      : sticky, set when a capture hits an unread result
module pwm_ramp_channel
  import pwm_ramp_pkg::*;
#(
  parameter int unsigned      NBITS       = 8,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [NBITS-1:0] PCNT_INIT   = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [NBITS-1:0] step_i,
  input  logic             lvds_i,
  input  logic             grant_i,
  output logic             pwm_o,
  output logic [NBITS-1:0] res_o,
  output logic             pend_o,
  output logic             overrun_o
);

  localparam logic [NBITS-1:0] MAX = NBITS'(max_cnt(NBITS));

  logic [NBITS-1:0]       pcnt_q, pcnt_d, ramp_q, ramp_d, res_q, res_d;
  logic                   pwm_q, pwm_d, pend_q, pend_d, ovr_q, ovr_d;
  logic                   swept_q, swept_d, prev_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [NBITS:0]         sum;
  logic                   period_end, sweep_end, rise, cap;

  always_comb begin
    sum        = {1'b0, ramp_q} + {1'b0, step_i};
    period_end = enable_i && (pcnt_q == MAX);
    sweep_end  = period_end && sum[NBITS];
    rise       = sync_q[SYNC_STAGES-1] && !prev_q;
    // swept_q marks that this sweep already produced its result; the wrap
    // itself captures MAX only when no edge did so earlier. Capture reads
    // ramp_q, i.e. the value before any same-cycle ramp update.
    cap        = enable_i && !swept_q && (rise || sweep_end);
    pcnt_d     = enable_i ? pcnt_q + NBITS'(1) : pcnt_q;
    ramp_d     = period_end ? sum[NBITS-1:0] : ramp_q;
    pwm_d      = enable_i && (pcnt_q < ramp_q);
    swept_d    = sweep_end ? 1'b0 : (swept_q || cap);
    res_d      = cap ? (rise ? ramp_q : MAX) : res_q;
    // A capture in the same cycle as the grant re-arms pend without overrun.
    pend_d     = cap || (pend_q && !grant_i);
    ovr_d      = ovr_q || (cap && pend_q && !grant_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pcnt_q  <= PCNT_INIT;
      ramp_q  <= '0;
      res_q   <= '0;
      pwm_q   <= 1'b0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      swept_q <= 1'b0;
      sync_q  <= '0;
      prev_q  <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      ramp_q  <= ramp_d;
      res_q   <= res_d;
      pwm_q   <= pwm_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      swept_q <= swept_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], lvds_i};
      prev_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pwm_o     = pwm_q;
  assign res_o     = res_q;
  assign pend_o    = pend_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/multi_pwm_ramp_adc.sv
// Multi-channel PWM ramp ADC top: NCH channels, round-robin arbiter and a
// single-register valid/ready output slice.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   enable_i              : global run
//   step_i                : ramp increment per PWM period
//   lvds_i[NCH]           : asynchronous comparator inputs
//   pwm_o[NCH]            : registered PWM outputs
//   adc_value_o/adc_chan_o: result and its channel
//   adc_valid_o/adc_ready_i: output handshake
//   overrun_o[NCH]        : sticky per-channel overrun flags
module multi_pwm_ramp_adc
  import pwm_ramp_pkg::*;
#(
  parameter  int unsigned NBITS       = 8,
  parameter  int unsigned NCH         = 2,
  parameter  int unsigned SYNC_STAGES = 2,
  localparam int unsigned CW          = cw_of(NCH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [NBITS-1:0] step_i,
  input  logic [NCH-1:0]   lvds_i,
  output logic [NCH-1:0]   pwm_o,
  output logic [NBITS-1:0] adc_value_o,
  output logic [CW-1:0]    adc_chan_o,
  output logic             adc_valid_o,
  input  logic             adc_ready_i,
  output logic [NCH-1:0]   overrun_o
);

  logic [NBITS-1:0] res [NCH];
  logic [NCH-1:0]   pend, grant;
  result_t          slice_q, slice_d;
  logic             valid_q, valid_d;
  logic [CW-1:0]    rr_q, rr_d, gidx, cand;
  logic             load, found;
  logic             unused_hi;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    pwm_ramp_channel #(
      .NBITS      (NBITS),
      .SYNC_STAGES(SYNC_STAGES),
      .PCNT_INIT  (NBITS'(k * ((1 << NBITS) / NCH)))
    ) u_ch (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .enable_i (enable_i),
      .step_i   (step_i),
      .lvds_i   (lvds_i[k]),
      .grant_i  (grant[k]),
      .pwm_o    (pwm_o[k]),
      .res_o    (res[k]),
      .pend_o   (pend[k]),
      .overrun_o(overrun_o[k])
    );
  end

  always_comb begin
    // Slice may load when empty or when its content leaves this cycle.
    load  = !valid_q || adc_ready_i;
    found = 1'b0;
    gidx  = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      cand = CW'((32'(rr_q) + i) % NCH);
      if (!found && pend[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
    grant   = '0;
    valid_d = valid_q;
    slice_d = slice_q;
    rr_d    = rr_q;
    if (load) begin
      valid_d = found;
      if (found) begin
        grant[gidx]   = 1'b1;
        slice_d.chan  = CHAN_W'(gidx);
        slice_d.value = RES_W'(res[gidx]);
        rr_d          = gidx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      slice_q <= '0;
      rr_q    <= CW'(NCH - 1);
    end else begin
      valid_q <= valid_d;
      slice_q <= slice_d;
      rr_q    <= rr_d;
    end
  end

  assign adc_valid_o = valid_q;
  assign adc_value_o = slice_q.value[NBITS-1:0];
  assign adc_chan_o  = slice_q.chan[CW-1:0];
  // Payload bits above the configured widths are always zero.
  assign unused_hi   = ^{slice_q.value >> NBITS, slice_q.chan >> CW};

endmodule

// File: tb/tb_multi_pwm_ramp_adc.sv
module tb_multi_pwm_ramp_adc;

  localparam int unsigned NBITS = 4;
  localparam int unsigned NCH   = 2;
  localparam int unsigned SS    = 2;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       enable_i = 1'b0;
  logic [3:0] step_i = '0;
  logic [1:0] lvds_i = '0;
  logic       adc_ready_i = 1'b0;
  logic [1:0] pwm_o;
  logic [3:0] adc_value_o;
  logic [0:0] adc_chan_o;
  logic       adc_valid_o;
  logic [1:0] overrun_o;

  int checks = 0;
  int errors = 0;
  int n = 0;

  always #5 clk = ~clk;

  multi_pwm_ramp_adc #(
    .NBITS(NBITS),
    .NCH(NCH),
    .SYNC_STAGES(SS)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .enable_i(enable_i),
    .step_i(step_i),
    .lvds_i(lvds_i),
    .pwm_o(pwm_o),
    .adc_value_o(adc_value_o),
    .adc_chan_o(adc_chan_o),
    .adc_valid_o(adc_valid_o),
    .adc_ready_i(adc_ready_i),
    .overrun_o(overrun_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    n = 0;
  endtask

  task automatic test_reset();
    logic [1:0] exp_pwm;
    enable_i = 1'b1; step_i = 4'd3; lvds_i = 2'b00; adc_ready_i = 1'b1;
    rst_i = 1'b1;
    tick();
    tick();
    checks++; if (pwm_o !== 2'b00) begin errors++; $display("FAIL reset_pwm: got %b expected 00", pwm_o); end
    checks++; if (adc_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", adc_valid_o); end
    checks++; if (adc_value_o !== 4'd0) begin errors++; $display("FAIL reset_value: got %0d expected 0", adc_value_o); end
    checks++; if (adc_chan_o !== 1'b0) begin errors++; $display("FAIL reset_chan: got %0d expected 0", adc_chan_o); end
    checks++; if (overrun_o !== 2'b00) begin errors++; $display("FAIL reset_overrun: got %b expected 00", overrun_o); end
    rst_i = 1'b0;
    n = 0;
    // ch1 starts at pcnt 8, so its first period ends after 8 cycles.
    repeat (17) begin
      tick();
      exp_pwm = (n >= 9 && n <= 11) ? 2'b10 : (n == 17) ? 2'b01 : 2'b00;
      checks++; if (pwm_o !== exp_pwm) begin errors++; $display("FAIL stagger_pwm n=%0d: got %b expected %b", n, pwm_o, exp_pwm); end
      checks++; if (adc_valid_o !== 1'b0) begin errors++; $display("FAIL stagger_valid n=%0d: got %b expected 0", n, adc_valid_o); end
    end
  endtask

  task automatic test_capture();
    logic exp_v;
    enable_i = 1'b1; step_i = 4'd3; lvds_i = 2'b00; adc_ready_i = 1'b1;
    apply_reset();
    while (n < 33) tick();
    lvds_i = 2'b01;
    while (n < 50) begin
      tick();
      exp_v = (n == 37);
      checks++; if (adc_valid_o !== exp_v) begin errors++; $display("FAIL capture_valid n=%0d: got %b expected %b", n, adc_valid_o, exp_v); end
      if (n == 37) begin
        checks++; if (adc_chan_o !== 1'b0) begin errors++; $display("FAIL capture_chan: got %0d expected 0", adc_chan_o); end
        checks++; if (adc_value_o !== 4'd6) begin errors++; $display("FAIL capture_value: got %0d expected 6", adc_value_o); end
      end
      if (n == 38) lvds_i = 2'b00;
      if (n == 40) lvds_i = 2'b01;
    end
    checks++; if (overrun_o !== 2'b00) begin errors++; $display("FAIL capture_overrun: got %b expected 00", overrun_o); end
  endtask

  task automatic test_wrap();
    logic exp_v;
    enable_i = 1'b1; step_i = 4'd4; lvds_i = 2'b00; adc_ready_i = 1'b1;
    apply_reset();
    while (n < 66) begin
      tick();
      exp_v = (n == 57) || (n == 65);
      checks++; if (adc_valid_o !== exp_v) begin errors++; $display("FAIL wrap_valid n=%0d: got %b expected %b", n, adc_valid_o, exp_v); end
      if (n == 57 || n == 65) begin
        checks++; if (adc_chan_o !== ((n == 57) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL wrap_chan n=%0d: got %0d expected %0d", n, adc_chan_o, (n == 57) ? 1 : 0); end
        checks++; if (adc_value_o !== 4'd15) begin errors++; $display("FAIL wrap_value n=%0d: got %0d expected 15", n, adc_value_o); end
      end
    end
  endtask

  task automatic test_overrun();
    enable_i = 1'b1; step_i = 4'd14; lvds_i = 2'b00; adc_ready_i = 1'b0;
    apply_reset();
    tick();
    lvds_i = 2'b10;
    while (n < 49) begin
      tick();
      if (n == 17) lvds_i = 2'b11;
      if (n >= 5) begin
        checks++; if (adc_valid_o !== 1'b1 || adc_chan_o !== 1'b1 || adc_value_o !== 4'd0) begin
          errors++; $display("FAIL hold_stable n=%0d: got v=%b ch=%0d val=%0d expected v=1 ch=1 val=0", n, adc_valid_o, adc_chan_o, adc_value_o);
        end
      end
    end
    checks++; if (overrun_o !== 2'b01) begin errors++; $display("FAIL overrun_flag: got %b expected 01", overrun_o); end
    enable_i = 1'b0;
    adc_ready_i = 1'b1;
    tick();
    checks++; if (adc_valid_o !== 1'b1 || adc_chan_o !== 1'b0 || adc_value_o !== 4'd15) begin
      errors++; $display("FAIL overrun_second n=%0d: got v=%b ch=%0d val=%0d expected v=1 ch=0 val=15", n, adc_valid_o, adc_chan_o, adc_value_o);
    end
    checks++; if (pwm_o !== 2'b00) begin errors++; $display("FAIL disabled_pwm: got %b expected 00", pwm_o); end
    tick();
    checks++; if (adc_valid_o !== 1'b1 || adc_chan_o !== 1'b1 || adc_value_o !== 4'd15) begin
      errors++; $display("FAIL overrun_ch1 n=%0d: got v=%b ch=%0d val=%0d expected v=1 ch=1 val=15", n, adc_valid_o, adc_chan_o, adc_value_o);
    end
    tick();
    checks++; if (adc_valid_o !== 1'b0) begin errors++; $display("FAIL overrun_drain: got %b expected 0", adc_valid_o); end
    checks++; if (overrun_o !== 2'b01) begin errors++; $display("FAIL overrun_sticky: got %b expected 01", overrun_o); end
  endtask

  task automatic test_back_to_back();
    logic       exp_v;
    logic [0:0] exp_c;
    logic [3:0] exp_d;
    enable_i = 1'b1; step_i = 4'd14; lvds_i = 2'b00; adc_ready_i = 1'b0;
    apply_reset();
    while (n < 45) begin
      tick();
      if (n == 39) lvds_i = 2'b01;
      if (n == 41) adc_ready_i = 1'b1;
      exp_v = (n >= 25 && n <= 44);
      exp_c = (n == 42 || n == 44) ? 1'b0 : 1'b1;
      exp_d = (n == 44) ? 4'd12 : 4'd15;
      checks++; if (adc_valid_o !== exp_v) begin errors++; $display("FAIL b2b_valid n=%0d: got %b expected %b", n, adc_valid_o, exp_v); end
      if (exp_v) begin
        checks++; if (adc_chan_o !== exp_c || adc_value_o !== exp_d) begin
          errors++; $display("FAIL b2b_data n=%0d: got ch=%0d val=%0d expected ch=%0d val=%0d", n, adc_chan_o, adc_value_o, exp_c, exp_d);
        end
      end
    end
    checks++; if (overrun_o !== 2'b00) begin errors++; $display("FAIL b2b_overrun: got %b expected 00", overrun_o); end
  endtask

  task automatic test_reset_midflight();
    enable_i = 1'b1; step_i = 4'd14; lvds_i = 2'b00; adc_ready_i = 1'b0;
    apply_reset();
    while (n < 26) tick();
    checks++; if (adc_valid_o !== 1'b1 || adc_chan_o !== 1'b1 || adc_value_o !== 4'd15) begin
      errors++; $display("FAIL midflight_pre: got v=%b ch=%0d val=%0d expected v=1 ch=1 val=15", adc_valid_o, adc_chan_o, adc_value_o);
    end
    rst_i = 1'b1;
    tick();
    checks++; if (adc_valid_o !== 1'b0) begin errors++; $display("FAIL midflight_valid: got %b expected 0", adc_valid_o); end
    checks++; if (adc_value_o !== 4'd0) begin errors++; $display("FAIL midflight_value: got %0d expected 0", adc_value_o); end
    checks++; if (adc_chan_o !== 1'b0) begin errors++; $display("FAIL midflight_chan: got %0d expected 0", adc_chan_o); end
    checks++; if (pwm_o !== 2'b00) begin errors++; $display("FAIL midflight_pwm: got %b expected 00", pwm_o); end
    checks++; if (overrun_o !== 2'b00) begin errors++; $display("FAIL midflight_overrun: got %b expected 00", overrun_o); end
    rst_i = 1'b0;
    adc_ready_i = 1'b1;
    n = 0;
    repeat (5) begin
      tick();
      checks++; if (adc_valid_o !== 1'b0) begin errors++; $display("FAIL midflight_lost n=%0d: got %b expected 0", n, adc_valid_o); end
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_wrap();
    test_overrun();
    test_back_to_back();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
